// File: rtl/spi_deserializer.sv
// spi_deserializer: oversampling SPI mode-0 receiver with valid/read handshake,
// overrun and framing-error reporting.
module spi_deserializer #(
    parameter int DATA_SIZE = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_CS,
    input  logic                 i_SCLK,
    input  logic                 i_MOSI,
    input  logic                 i_Data_Read,
    output logic [DATA_SIZE-1:0] o_Data,
    output logic                 o_Data_Valid,
    output logic                 o_Overrun,
    output logic                 o_Frame_Error,
    output logic                 o_Busy
);
    localparam int CW = $clog2(DATA_SIZE);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [2:0]           cs_q, cs_d, sclk_q, sclk_d;
    logic [1:0]           mosi_q, mosi_d;
    logic [0:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d, data_q, data_d, word;
    logic                 valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic                 sclk_rise, cs_rise, shifting, take, done, rd;

    always_comb begin
        cs_d        = {cs_q[1:0], i_CS};
        sclk_d      = {sclk_q[1:0], i_SCLK};
        mosi_d      = {mosi_q[0], i_MOSI};
        sclk_rise   = sclk_q[1] & ~sclk_q[2];
        cs_rise     = cs_q[1] & ~cs_q[2];
        // a SCLK rise coinciding with synced CS high is dropped: CS wins
        shifting    = (state_q == SHIFT) && !cs_q[1];
        take        = shifting && sclk_rise;
        word        = MSB_FIRST ? {shift_q[DATA_SIZE-2:0], mosi_q[1]}
                                : {mosi_q[1], shift_q[DATA_SIZE-1:1]};
        done        = take && (cnt_q == CW'(DATA_SIZE - 1));
        rd          = i_Data_Read && valid_q;
        state_d     = cs_q[1] ? IDLE : SHIFT;
        cnt_d       = shifting ? (take ? cnt_q + 1'b1 : cnt_q) : '0;
        shift_d     = take ? word : shift_q;
        frame_err_d = (state_q == SHIFT) && cs_rise && (cnt_q != '0);
        data_d      = (done && (!valid_q || rd)) ? word : data_q;
        valid_d     = done || (valid_q && !rd);
        overrun_d   = (done && valid_q && !rd) ? 1'b1 : (rd ? 1'b0 : overrun_q);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            cs_q        <= 3'b111;
            sclk_q      <= '0;
            mosi_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_Data        = data_q;
    assign o_Data_Valid  = valid_q;
    assign o_Overrun     = overrun_q;
    assign o_Frame_Error = frame_err_q;
    assign o_Busy        = state_q;
endmodule

// File: tb/tb_spi_deserializer.sv
// tb_spi_deserializer: directed SPI frames into an LSB-first and an MSB-first
// receiver; expected words are queued and checked by per-receiver monitors.
module tb_spi_deserializer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cs_a = 1'b1, cs_b = 1'b1, sclk = 1'b0, mosi = 1'b0, rd_a = 1'b0, rd_b = 1'b0;
    logic [31:0] da, db;
    logic        va, vb, ova, ovb, fea, feb, bsa, bsb;
    logic [31:0] q_a[$], q_b[$];
    int          tests = 0, fails = 0, fe_a = 0, fe_b = 0;
    logic        pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;

    spi_deserializer #(.DATA_SIZE(32), .MSB_FIRST(1'b0)) dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_CS(cs_a), .i_SCLK(sclk), .i_MOSI(mosi),
        .i_Data_Read(rd_a), .o_Data(da), .o_Data_Valid(va), .o_Overrun(ova),
        .o_Frame_Error(fea), .o_Busy(bsa));

    spi_deserializer #(.DATA_SIZE(32), .MSB_FIRST(1'b1)) dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_CS(cs_b), .i_SCLK(sclk), .i_MOSI(mosi),
        .i_Data_Read(rd_b), .o_Data(db), .o_Data_Valid(vb), .o_Overrun(ovb),
        .o_Frame_Error(feb), .o_Busy(bsb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // a new word is presented when valid rises or reloads under a same-cycle read
    always @(negedge clk) begin
        if (va && (!pv_a || pr_a)) begin
            if (q_a.size() == 0) begin
                tests++; fails++;
                $display("FAIL word_a: unexpected word %h", da);
            end else chk("word_a", 64'(da), 64'(q_a.pop_front()));
        end
        if (vb && (!pv_b || pr_b)) begin
            if (q_b.size() == 0) begin
                tests++; fails++;
                $display("FAIL word_b: unexpected word %h", db);
            end else chk("word_b", 64'(db), 64'(q_b.pop_front()));
        end
        if (fea) fe_a <= fe_a + 1;
        if (feb) fe_b <= fe_b + 1;
        pv_a <= va; pr_a <= rd_a & va;
        pv_b <= vb; pr_b <= rd_b & vb;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [31:0] w, input int nbits, input bit msb,
                        input bit rdc, input bit lat, input bit hold);
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = msb ? w[31-i] : w[i];
            tick(4);
            sclk = 1'b1;
            if (i == nbits - 1 && (lat || rdc)) begin
                tick(2);
                if (lat) chk("lat_pre", 64'(va), 64'd0);
                if (rdc) rd_a = 1'b1;
                tick(1);
                rd_a = 1'b0;
                if (lat) chk("lat_post", 64'(va), 64'd1);
                tick(1);
            end else tick(4);
            sclk = 1'b0;
        end
        if (!hold) begin
            tick(4);
            if (sel) cs_b = 1'b1; else cs_a = 1'b1;
            tick(8);
        end
    endtask

    task automatic read_a();
        rd_a = 1'b1; tick(1); rd_a = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("reset_a", {da, va, ova, fea, bsa}, 64'd0);
        chk("reset_b", {db, vb, ovb, feb, bsb}, 64'd0);
        rst = 1'b0;
        tick(4);
        q_a.push_back(32'hA5C30F81);
        send(0, 32'hA5C30F81, 32, 0, 0, 1, 0);
        chk("t1_flags", {va, ova, 32'(fe_a)}, {1'b1, 1'b0, 32'd0});
        read_a();
        chk("t1_read", 64'(va), 64'd0);
        q_a.push_back(32'h00000001);
        send(0, 32'h00000001, 32, 0, 0, 0, 0);
        send(0, 32'hFFFFFFFF, 32, 0, 0, 0, 0);
        chk("t2_overrun", {da, va, ova}, {32'h00000001, 1'b1, 1'b1});
        read_a();
        chk("t2_read", {va, ova}, 64'd0);
        q_a.push_back(32'hCAFEF00D);
        send(0, 32'hCAFEF00D, 32, 0, 0, 0, 0);
        q_a.push_back(32'h12345678);
        send(0, 32'h12345678, 32, 0, 1, 0, 0);
        chk("t3_same_cycle", {da, va, ova}, {32'h12345678, 1'b1, 1'b0});
        read_a();
        send(0, 32'h0000007F, 7, 0, 0, 0, 0);
        chk("t4_frame_err", {da, va, 32'(fe_a)}, {32'h12345678, 1'b0, 32'd1});
        q_a.push_back(32'hDEADBEEF);
        send(0, 32'hDEADBEEF, 32, 0, 0, 0, 0);
        chk("t4_after", {va, ova, 32'(fe_a)}, {1'b1, 1'b0, 32'd1});
        send(0, 32'h5555AAAA, 12, 0, 0, 0, 1);
        chk("t5_busy", 64'(bsa), 64'd1);
        #3 rst = 1'b1;
        #1 chk("t5_async_a", {da, va, ova, fea, bsa}, 64'd0);
        chk("t5_async_b", {db, vb, ovb, feb, bsb}, 64'd0);
        cs_a = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        q_a.push_back(32'h0000FFFF);
        send(0, 32'h0000FFFF, 32, 0, 0, 0, 0);
        chk("t5_after", {da, va, ova, 32'(fe_a)}, {32'h0000FFFF, 1'b1, 1'b0, 32'd1});
        read_a();
        chk("t6_b_idle", {vb, bsb, 32'(fe_b)}, 64'd0);
        q_b.push_back(32'h80000001);
        send(1, 32'h80000001, 32, 1, 0, 0, 0);
        chk("t6_b_word", {db, vb}, {32'h80000001, 1'b1});
        rd_b = 1'b1; tick(1); rd_b = 1'b0;
        q_b.push_back(32'h12345678);
        send(1, 32'h12345678, 32, 1, 0, 0, 0);
        chk("t6_b_order", {db, vb, ovb, 32'(fe_b)}, {32'h12345678, 1'b1, 1'b0, 32'd0});
        tick(10);
        chk("queues_empty", 64'(q_a.size() + q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_deserializer.md
Name: spi_deserializer

Overview:
- SPI receive stage; consumes the CS/SCLK/MOSI stream produced by the team's serializer (mode 0: SCLK idle low, MOSI changes on SCLK fall, sampled on SCLK rise, CS active low, one word per CS frame, LSB first by default).
- Oversamples the three SPI lines in the local clock domain and reassembles each word.
- Presents each word through a valid/read handshake with overrun and framing-error reporting.
- Sits at the far end of the SPI link, e.g. in a loopback test or a receiving FPGA.

Parameters:
- DATA_SIZE, 32, bits per word; power of 2, at least 2.
- MSB_FIRST, 0, 0 = first received bit is bit 0 (matches serializer); 1 = first received bit is bit DATA_SIZE-1.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_CS  input  1  SPI chip select, active low, asynchronous to i_Clock.
- i_SCLK  input  1  SPI clock, idle low, asynchronous.
- i_MOSI  input  1  SPI data, asynchronous.
- i_Data_Read  input  1  consumer acknowledges o_Data; effective only while o_Data_Valid=1.
- o_Data  output  DATA_SIZE  last completed word.
- o_Data_Valid  output  1  high from word completion until read.
- o_Overrun  output  1  sticky; a word was dropped because o_Data was unread.
- o_Frame_Error  output  1  one-cycle pulse; CS deasserted mid-word.
- o_Busy  output  1  high while the synchronised CS is low (frame in progress).

Behaviour:
- Interface: one clock (i_Clock); reset i_Reset is asynchronous and active-high.
- Reset values: o_Data=0, o_Data_Valid=0, o_Overrun=0, o_Frame_Error=0, o_Busy=0.
- Reset state: shift register 0, bit counter 0, all synchroniser flops: CS=1, SCLK=0, MOSI=0.
- Synchronisers:
  - CS, SCLK and MOSI each pass through 2 flops (s1, s2).
  - SCLK and CS also have a third delay flop (s3) for edge detection.
  - sclk_rise = s2 & ~s3. cs_rise = s2 & ~s3 on the CS chain.
- Input timing requirement: SCLK high and low phases each at least 2 i_Clock periods. MOSI stable around SCLK rise, guaranteed by the serializer.
- States (2):
  - IDLE: synced CS high. o_Busy=0. Bit counter held at 0. SCLK edges ignored.
  - IDLE -> SHIFT: on synced CS low.
  - SHIFT: o_Busy=1. On each sclk_rise, shift in synced MOSI and increment the bit counter.
  - LSB-first shifting: register shifts right, new bit enters at the MSB. MSB-first shifting: register shifts left, new bit enters at bit 0.
  - SHIFT -> IDLE: on synced CS high.
- Word completion: the sclk_rise with counter = DATA_SIZE-1.
  - Counter wraps to 0, so further words are allowed within one frame.
  - The completed word, including the current bit, is offered to the output register in the same cycle.
- Latency: o_Data_Valid rises on the 2nd i_Clock edge after the edge at which s1 first captures the final SCLK high.
- Output handshake:
  - Completion with o_Data_Valid=0: load o_Data, set o_Data_Valid.
  - i_Data_Read with o_Data_Valid=1: clear o_Data_Valid next edge, clear o_Overrun.
  - Completion and i_Data_Read in the same cycle: new word loads, o_Data_Valid stays 1, no overrun.
  - Completion with o_Data_Valid=1 and no read: new word discarded, o_Data unchanged, o_Overrun set.
  - i_Data_Read while o_Data_Valid=0: ignored.
- Framing:
  - cs_rise in SHIFT with counter != 0: o_Frame_Error pulses for 1 cycle, counter resets to 0, partial word discarded, o_Data unchanged.
  - cs_rise with counter = 0: no error.
  - sclk_rise in the same cycle as synced CS high: ignored (CS wins).
- Reset mid-frame: all state cleared immediately. Bits received before reset are lost. A frame whose CS is still low after reset release is received starting from the next SCLK rise.

Test Plan:
- DATA_SIZE=32, MSB_FIRST=0, SCLK = i_Clock/8. Send 0xA5C30F81 LSB-first in one CS frame -> o_Data=0xA5C30F81; o_Data_Valid rises 2 edges after s1 samples the 32nd SCLK high; no error flags.
- Two frames (0x00000001, then 0xFFFFFFFF) with no i_Data_Read -> o_Data stays 0x00000001, o_Data_Valid=1, o_Overrun=1. Pulse i_Data_Read -> o_Data_Valid=0 and o_Overrun=0 next cycle.
- Assert i_Data_Read exactly in the completion cycle of a second word 0x12345678 -> o_Data=0x12345678, o_Data_Valid stays 1, o_Overrun=0.
- 7 SCLK pulses then CS high -> one-cycle o_Frame_Error, o_Data_Valid stays 0. A following full frame of 0xDEADBEEF is received correctly.
- Assert i_Reset asynchronously after 12 bits -> all outputs 0 immediately. After release, a new frame of 0x0000FFFF is received correctly.
- MSB_FIRST=1: send 0x80000001 MSB-first -> o_Data=0x80000001. SCLK toggling while CS is high -> no valid, counter stays 0.
